// File: rtl/alu_regfile_datapath_pkg.sv
// Shared constants for the ALU / register-file datapath: opcodes and mux selects.
package alu_regfile_datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SAR  = 4'd7,
    ALU_MOV  = 4'd8,
    ALU_NOT  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_ANDN = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SLTU = 4'd13,
    ALU_SEQ  = 4'd14,
    ALU_SNE  = 4'd15
  } alu_op_e;

  localparam logic A_SEL_REG = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_REG = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;
  localparam logic W_SEL_ALU = 1'b0;
  localparam logic W_SEL_MEM = 1'b1;

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Control/data bundle between the instruction sequencer and the datapath.
interface alu_regfile_datapath_if #(
  parameter int WIDTH = 32,
  parameter int ABITS = 4
);
  logic             we;
  logic [ABITS-1:0] wsel;
  logic [ABITS-1:0] asel;
  logic [ABITS-1:0] bsel;
  logic [3:0]       aluop;
  logic             a_sel;
  logic             b_sel;
  logic [29:0]      pc;
  logic [15:0]      imm16;
  logic             w_sel;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] aluout;

  modport master (
    output we, wsel, asel, bsel, aluop, a_sel, b_sel, pc, imm16, w_sel, mem_rdata,
    input  reg_a, reg_b, aluout
  );

  modport slave (
    input  we, wsel, asel, bsel, aluop, a_sel, b_sel, pc, imm16, w_sel, mem_rdata,
    output reg_a, reg_b, aluout
  );
endinterface

// File: rtl/alu_regfile_datapath_alu.sv
// Combinational ALU; carry and overflow are discarded, compares yield 0 or 1.
module alu
  import alu_regfile_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [4:0]              shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  function automatic logic [WIDTH-1:0] flag(input logic c);
    return {{(WIDTH-1){1'b0}}, c};
  endfunction

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SHL:  y = a << shamt;
      ALU_SHR:  y = a >> shamt;
      ALU_SAR:  y = a_s >>> shamt;
      ALU_MOV:  y = b;
      ALU_NOT:  y = ~a;
      ALU_NOR:  y = ~(a | b);
      ALU_ANDN: y = a & ~b;
      ALU_SLT:  y = flag(a_s < b_s);
      ALU_SLTU: y = flag(a < b);
      ALU_SEQ:  y = flag(a == b);
      ALU_SNE:  y = flag(a != b);
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/alu_regfile_datapath_mux2.sv
// Generic two-input select.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/alu_regfile_datapath_regfile.sv
// Register file: two combinational read ports, one synchronous write port, no bypass.
module regfile #(
  parameter int WIDTH = 32,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ABITS-1:0] wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] asel,
  input  logic [ABITS-1:0] bsel,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b
);
  localparam int NREGS = 2 ** ABITS;

  logic [WIDTH-1:0] regs [NREGS];

  // Reset has priority over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign rd_a = regs[asel];
  assign rd_b = regs[bsel];
endmodule

// File: rtl/alu_regfile_datapath.sv
// Single-cycle datapath: register file feeding an ALU through operand muxes, with load/ALU write-back select.
module alu_regfile_datapath
  import alu_regfile_datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ABITS = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_regfile_datapath_if.slave bus
);
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] pc_ext;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] wdata;

  // pc and imm16 are zero-extended into the datapath width.
  assign pc_ext  = WIDTH'(bus.pc);
  assign imm_ext = WIDTH'(bus.imm16);

  regfile #(.WIDTH(WIDTH), .ABITS(ABITS)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.we),
    .wsel  (bus.wsel),
    .wdata (wdata),
    .asel  (bus.asel),
    .bsel  (bus.bsel),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  mux2 #(.W(WIDTH)) u_mux_a (.sel(bus.a_sel), .d0(rd_a),  .d1(pc_ext),        .y(op_a));
  mux2 #(.W(WIDTH)) u_mux_b (.sel(bus.b_sel), .d0(rd_b),  .d1(imm_ext),       .y(op_b));
  mux2 #(.W(WIDTH)) u_mux_w (.sel(bus.w_sel), .d0(alu_y), .d1(bus.mem_rdata), .y(wdata));

  alu #(.WIDTH(WIDTH)) u_alu (
    .op (bus.aluop),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  assign bus.reg_a  = rd_a;
  assign bus.reg_b  = rd_b;
  assign bus.aluout = alu_y;
endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath with hand-computed expected values.
module tb_alu_regfile_datapath;
  import alu_regfile_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_regfile_datapath_if #(.WIDTH(32), .ABITS(4)) bus ();

  alu_regfile_datapath #(.WIDTH(32), .ABITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wsel = '0; bus.asel = '0; bus.bsel = '0;
    bus.aluop = 4'd0; bus.a_sel = A_SEL_REG; bus.b_sel = B_SEL_REG;
    bus.pc = '0; bus.imm16 = '0; bus.w_sel = W_SEL_ALU; bus.mem_rdata = '0;
  endtask

  // Load a register from mem_rdata; inputs change at negedge, write lands at next posedge.
  task automatic load(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1; bus.wsel = idx; bus.w_sel = W_SEL_MEM; bus.mem_rdata = data;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.w_sel = W_SEL_ALU;
  endtask

  task automatic op_rr(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                       input alu_op_e op, input logic [31:0] exp);
    @(negedge clk);
    bus.a_sel = A_SEL_REG; bus.b_sel = B_SEL_REG;
    bus.asel = ra; bus.bsel = rb; bus.aluop = op;
    #1 chk(tag, bus.aluout, exp);
  endtask

  typedef struct { string tag; alu_op_e op; logic [31:0] exp; } vec_t;
  vec_t vecs[16];

  initial begin
    // A = R6 = F0F0_1234, B = R8 = 0FF0_0003 (shift amount 3)
    vecs[0]  = '{"add",  ALU_ADD,  32'h00E0_1237};
    vecs[1]  = '{"sub",  ALU_SUB,  32'hE100_1231};
    vecs[2]  = '{"and",  ALU_AND,  32'h00F0_0000};
    vecs[3]  = '{"or",   ALU_OR,   32'hFFF0_1237};
    vecs[4]  = '{"xor",  ALU_XOR,  32'hFF00_1237};
    vecs[5]  = '{"shl",  ALU_SHL,  32'h8780_91A0};
    vecs[6]  = '{"shr",  ALU_SHR,  32'h1E1E_0246};
    vecs[7]  = '{"sar",  ALU_SAR,  32'hFE1E_0246};
    vecs[8]  = '{"mov",  ALU_MOV,  32'h0FF0_0003};
    vecs[9]  = '{"not",  ALU_NOT,  32'h0F0F_EDCB};
    vecs[10] = '{"nor",  ALU_NOR,  32'h000F_EDC8};
    vecs[11] = '{"andn", ALU_ANDN, 32'hF000_1234};
    vecs[12] = '{"slt",  ALU_SLT,  32'h0000_0001};
    vecs[13] = '{"sltu", ALU_SLTU, 32'h0000_0000};
    vecs[14] = '{"seq",  ALU_SEQ,  32'h0000_0000};
    vecs[15] = '{"sne",  ALU_SNE,  32'h0000_0001};

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Every register reads zero after reset, on both ports
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.asel = 4'(i); bus.bsel = 4'(15 - i);
      #1;
      chk($sformatf("rst_a[%0d]", i), bus.reg_a, 32'h0);
      chk($sformatf("rst_b[%0d]", 15 - i), bus.reg_b, 32'h0);
    end

    // R3 = 5 via load path, then R3 + zero-extended 0xFFFF
    load(4'd3, 32'h0000_0005);
    @(negedge clk);
    bus.asel = 4'd3; bus.a_sel = A_SEL_REG; bus.b_sel = B_SEL_IMM;
    bus.imm16 = 16'hFFFF; bus.aluop = ALU_ADD;
    #1 chk("r3_add_imm", bus.aluout, 32'h0001_0004);

    // ALU write-back path: R4 = R3 + 0x10
    @(negedge clk);
    bus.imm16 = 16'h0010; bus.we = 1'b1; bus.wsel = 4'd4; bus.w_sel = W_SEL_ALU;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.bsel = 4'd4;
    #1 chk("r4_alu_wb", bus.reg_b, 32'h0000_0015);
    chk("r3_kept", bus.reg_a, 32'h0000_0005);

    // Signed vs unsigned compares and shifts on 0x8000_0000
    load(4'd1, 32'h8000_0000);
    load(4'd2, 32'h0000_0001);
    op_rr("slt_r1_r2",  4'd1, 4'd2, ALU_SLT,  32'h1);
    op_rr("sltu_r1_r2", 4'd1, 4'd2, ALU_SLTU, 32'h0);
    @(negedge clk);
    bus.b_sel = B_SEL_IMM; bus.imm16 = 16'd4; bus.aluop = ALU_SAR;
    #1 chk("sar4", bus.aluout, 32'hF800_0000);
    bus.aluop = ALU_SHR;
    #1 chk("shr4", bus.aluout, 32'h0800_0000);

    // Full opcode sweep on register operands
    load(4'd6, 32'hF0F0_1234);
    load(4'd8, 32'h0FF0_0003);
    foreach (vecs[k]) op_rr(vecs[k].tag, 4'd6, 4'd8, vecs[k].op, vecs[k].exp);
    op_rr("seq_same", 4'd6, 4'd6, ALU_SEQ, 32'h1);
    op_rr("sne_same", 4'd6, 4'd6, ALU_SNE, 32'h0);

    // Read of the register being written returns the old value until the edge
    @(negedge clk);
    bus.asel = 4'd5; bus.we = 1'b1; bus.wsel = 4'd5;
    bus.w_sel = W_SEL_MEM; bus.mem_rdata = 32'hAAAA_AAAA;
    #1 chk("r5_before_edge", bus.reg_a, 32'h0);
    @(posedge clk); #1;
    bus.we = 1'b0;
    chk("r5_after_edge", bus.reg_a, 32'hAAAA_AAAA);

    // pc operand zero-extended; carry into bit 30
    @(negedge clk);
    bus.a_sel = A_SEL_PC; bus.pc = 30'h3FFF_FFFF;
    bus.b_sel = B_SEL_IMM; bus.imm16 = 16'h0001; bus.aluop = ALU_ADD;
    #1 chk("pc_add", bus.aluout, 32'h4000_0000);
    bus.a_sel = A_SEL_REG;

    // rst asserted mid-cycle has no effect until the edge
    load(4'd9, 32'h0000_0055);
    @(negedge clk);
    bus.asel = 4'd9; rst = 1'b1;
    bus.we = 1'b1; bus.wsel = 4'd7; bus.w_sel = W_SEL_MEM; bus.mem_rdata = 32'h1234_5678;
    #1 chk("r9_mid_rst", bus.reg_a, 32'h0000_0055);

    // Reset beats a coincident write to R7
    @(posedge clk); #1;
    rst = 1'b0; bus.we = 1'b0;
    chk("r9_cleared", bus.reg_a, 32'h0);
    bus.asel = 4'd7; bus.bsel = 4'd5;
    #1 chk("r7_no_write", bus.reg_a, 32'h0);
    chk("r5_cleared", bus.reg_b, 32'h0);

    // 0 - 1 wraps
    @(negedge clk);
    bus.b_sel = B_SEL_IMM; bus.imm16 = 16'h0001; bus.aluop = ALU_SUB;
    #1 chk("sub_wrap", bus.aluout, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
